seq_divider: RTL and testbench

Parametrised multi-cycle integer divider producing quotient and remainder for unsigned or signed operands. It is a restoring shift-subtract engine with one quotient bit per clock, a start/done handshake and divide-by-zero reporting. It sits beside the combinational add/subtract ALU in the datapath and replaces single-width, single-mode division with a WIDTH-generic, signed-capable unit.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus shared by seq_divider and its requester.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, signed or unsigned operands,
// start/done handshake with divide-by-zero reporting.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_part;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz_out;

    logic             w_accept;
    logic             w_last;
    logic             w_zero;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_busy;
    logic             w_done;

    always_comb begin
        w_accept  = bus.start && ((r_state == StIdle) || (r_state == StDone));
        w_zero    = (bus.divisor == '0);
        w_dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
        w_dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
        w_dvs_mag = w_dvs_neg ? -bus.divisor : bus.divisor;
        w_last    = (r_cnt == CntW'(WIDTH - 1));
        // Trial subtraction is one bit wider so its MSB is the borrow.
        w_shift   = {r_part, r_dvd[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_dvs};
        w_q_fix   = r_dz ? '1 : (r_q_neg ? -r_dvd : r_dvd);
        w_r_fix   = r_dz ? r_dvd : (r_r_neg ? -r_part : r_part);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start) w_state_next = w_zero ? StFix : StCalc;
            end
            StCalc: begin
                if (w_last) w_state_next = StFix;
            end
            StFix: begin
                w_state_next = StDone;
            end
            StDone: begin
                if (bus.start) w_state_next = w_zero ? StFix : StCalc;
                else           w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_busy = (r_state == StCalc) || (r_state == StFix);
        w_done = (r_state == StDone);
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dz_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz     <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_part   <= '0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dz_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                r_r_neg <= w_dvd_neg;
                r_dz    <= w_zero;
                // A zero divisor skips CALC, so keep the raw dividend for the remainder.
                r_dvd   <= w_zero ? bus.dividend : w_dvd_mag;
                r_dvs   <= w_dvs_mag;
                r_part  <= '0;
                r_cnt   <= '0;
            end else if (r_state == StCalc) begin
                r_part <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_dvd  <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
                r_cnt  <= r_cnt + CntW'(1);
            end
            if (r_state == StFix) begin
                r_quot   <= w_q_fix;
                r_rem    <= w_r_fix;
                r_dz_out <= r_dz;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: 32-bit directed scenarios and an 8-bit random sweep
// against an arithmetic reference model.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) bus32 ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    seq_divider #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    // Reference: truncating division on 64-bit integers, results masked to w bits.
    function automatic void ref_div(input int unsigned w, input logic [31:0] a,
                                    input logic [31:0] b, input logic sm,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        longint      sa, sb, lq, lr;
        logic [31:0] mask, am, bm;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = a & mask;
        bm   = b & mask;
        if (bm == 32'd0) begin
            q  = mask;
            r  = am;
            dz = 1'b1;
        end else begin
            sa = longint'({32'd0, am});
            sb = longint'({32'd0, bm});
            if (sm && am[w-1]) sa = sa - (longint'(1) << w);
            if (sm && bm[w-1]) sb = sb - (longint'(1) << w);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0] & mask;
            r  = lr[31:0] & mask;
            dz = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0; returns in cycle 1 with start dropped.
    task automatic launch32(input logic [31:0] a, input logic [31:0] b, input logic sm);
        bus32.dividend    = a;
        bus32.divisor     = b;
        bus32.signed_mode = sm;
        bus32.start       = 1'b1;
        step();
        bus32.start = 1'b0;
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        bus8.dividend    = a;
        bus8.divisor     = b;
        bus8.signed_mode = sm;
        bus8.start       = 1'b1;
        step();
        bus8.start = 1'b0;
    endtask

    // Counts cycles until done (bounded); flags any cycle where busy disagrees.
    task automatic wait32(output int cyc, output logic busy_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (bus32.done !== 1'b1 && cyc < 100) begin
            if (bus32.busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        if (bus32.busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic wait8(output int cyc);
        cyc = 1;
        while (bus8.done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
        bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
        rst = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({bus32.busy, bus32.done, bus32.div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags32: got busy/done/dz=%b, expected 000",
                     {bus32.busy, bus32.done, bus32.div_by_zero});
        end
        n_tests++;
        if ({bus32.quotient, bus32.remainder} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_results32: got q=%h r=%h, expected 0 0",
                     bus32.quotient, bus32.remainder);
        end
        n_tests++;
        if ({bus8.busy, bus8.done, bus8.div_by_zero, bus8.quotient, bus8.remainder} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_all8: got q=%h r=%h flags=%b, expected all 0",
                     bus8.quotient, bus8.remainder, {bus8.busy, bus8.done, bus8.div_by_zero});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_unsigned();
        int   cyc;
        logic bok;
        launch32(32'd100, 32'd7, 1'b0);
        wait32(cyc, bok);
        n_tests++;
        if (cyc !== 34) begin
            n_fail++;
            $display("FAIL unsigned_done_cycle: got %0d, expected 34", cyc);
        end
        n_tests++;
        if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL unsigned_busy_window: got ok=%b, expected 1", bok);
        end
        n_tests++;
        if ({bus32.quotient, bus32.remainder, bus32.div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL unsigned_result: got q=%0d r=%0d dz=%b, expected q=14 r=2 dz=0",
                     bus32.quotient, bus32.remainder, bus32.div_by_zero);
        end
        step();
        n_tests++;
        if (bus32.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: got done=%b, expected 0", bus32.done);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [5] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'd7};
        logic [31:0] tb [5] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] eq, er;
        logic        edz, bok;
        int          cyc;
        for (int i = 0; i < 5; i++) begin
            ref_div(32, ta[i], tb[i], 1'b1, eq, er, edz);
            launch32(ta[i], tb[i], 1'b1);
            wait32(cyc, bok);
            n_tests++;
            if (cyc !== 34 || bok !== 1'b1) begin
                n_fail++;
                $display("FAIL signed_timing[%0d]: got cycle=%0d busy_ok=%b, expected 34 1",
                         i, cyc, bok);
            end
            n_tests++;
            if ({bus32.quotient, bus32.remainder, bus32.div_by_zero} !== {eq, er, edz}) begin
                n_fail++;
                $display("FAIL signed_result[%0d]: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                         i, bus32.quotient, bus32.remainder, bus32.div_by_zero, eq, er, edz);
            end
        end
    endtask

    task automatic test_div_zero();
        int   cyc;
        logic bok;
        for (int m = 0; m < 2; m++) begin
            launch32(32'h1234_5678, 32'd0, m[0]);
            wait32(cyc, bok);
            n_tests++;
            if (cyc !== 2 || bok !== 1'b1) begin
                n_fail++;
                $display("FAIL divzero_timing[mode%0d]: got cycle=%0d busy_ok=%b, expected 2 1",
                         m, cyc, bok);
            end
            n_tests++;
            if ({bus32.quotient, bus32.remainder, bus32.div_by_zero} !==
                {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) begin
                n_fail++;
                $display("FAIL divzero_result[mode%0d]: got q=%h r=%h dz=%b, expected ffffffff 12345678 1",
                         m, bus32.quotient, bus32.remainder, bus32.div_by_zero);
            end
        end
        launch32(32'd100, 32'd7, 1'b0);
        wait32(cyc, bok);
        n_tests++;
        if ({bus32.quotient, bus32.div_by_zero} !== {32'd14, 1'b0}) begin
            n_fail++;
            $display("FAIL divzero_clears: got q=%0d dz=%b, expected 14 0",
                     bus32.quotient, bus32.div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] eq, er;
        logic        edz;
        int          cyc;
        ref_div(32, 32'd5000, 32'd13, 1'b0, eq, er, edz);
        launch32(32'd5000, 32'd13, 1'b0);
        cyc = 1;
        while (bus32.done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                bus32.dividend = 32'd999;
                bus32.divisor  = 32'd0;
                bus32.start    = 1'b1;
            end else begin
                bus32.start = 1'b0;
            end
            step();
            cyc++;
        end
        bus32.start = 1'b0;
        n_tests++;
        if (cyc !== 34) begin
            n_fail++;
            $display("FAIL ignore_start_cycle: got %0d, expected 34", cyc);
        end
        n_tests++;
        if ({bus32.quotient, bus32.remainder, bus32.div_by_zero} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL ignore_start_result: got q=%0d r=%0d dz=%b, expected q=%0d r=%0d dz=%b",
                     bus32.quotient, bus32.remainder, bus32.div_by_zero, eq, er, edz);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, er;
        logic        edz, bok;
        int          cyc;
        launch32(32'd77, 32'd5, 1'b0);
        wait32(cyc, bok);
        n_tests++;
        if ({bus32.quotient, bus32.remainder} !== {32'd15, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%0d r=%0d, expected 15 2",
                     bus32.quotient, bus32.remainder);
        end
        // Still in the done cycle: the next request is issued here.
        ref_div(32, 32'hFFFF_FC18, 32'd33, 1'b1, eq, er, edz);
        launch32(32'hFFFF_FC18, 32'd33, 1'b1);
        wait32(cyc, bok);
        n_tests++;
        if (cyc !== 34 || bok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timing: got cycle=%0d busy_ok=%b, expected 34 1", cyc, bok);
        end
        n_tests++;
        if ({bus32.quotient, bus32.remainder, bus32.div_by_zero} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                     bus32.quotient, bus32.remainder, bus32.div_by_zero, eq, er, edz);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] eq, er;
        logic        edz, bok, saw_done;
        int          cyc;
        launch32(32'd1000, 32'd3, 1'b0);
        repeat (9) step();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus32.busy, bus32.done, bus32.div_by_zero, bus32.quotient, bus32.remainder} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b dz=%b q=%h r=%h, expected all 0",
                     bus32.busy, bus32.done, bus32.div_by_zero, bus32.quotient, bus32.remainder);
        end
        step();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) saw_done = 1'b1;
            step();
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got activity=%b, expected 0", saw_done);
        end
        ref_div(32, 32'd200, 32'd9, 1'b0, eq, er, edz);
        launch32(32'd200, 32'd9, 1'b0);
        wait32(cyc, bok);
        n_tests++;
        if (cyc !== 34 || {bus32.quotient, bus32.remainder, bus32.div_by_zero} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got cycle=%0d q=%0d r=%0d, expected 34 q=%0d r=%0d",
                     cyc, bus32.quotient, bus32.remainder, eq, er);
        end
        step();
    endtask

    task automatic test_random8();
        logic [31:0] eq, er;
        logic        edz;
        logic [7:0]  a, b;
        logic        sm;
        int          cyc, exp_cyc;
        logic [7:0]  ea [4] = '{8'h80, 8'h00, 8'hFF, 8'h7F};
        logic [7:0]  eb [4] = '{8'hFF, 8'h05, 8'h01, 8'h80};
        for (int i = 0; i < 400; i++) begin
            if (i < 8) begin
                a  = ea[i % 4];
                b  = eb[i % 4];
                sm = (i >= 4);
            end else begin
                a  = 8'($urandom_range(0, 255));
                b  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                sm = 1'($urandom_range(0, 1));
            end
            ref_div(8, {24'd0, a}, {24'd0, b}, sm, eq, er, edz);
            exp_cyc = (b == 8'd0) ? 2 : 10;
            launch8(a, b, sm);
            wait8(cyc);
            n_tests++;
            if (cyc !== exp_cyc ||
                {bus8.quotient, bus8.remainder, bus8.div_by_zero} !== {eq[7:0], er[7:0], edz}) begin
                n_fail++;
                $display("FAIL rand8 %h/%h s=%b: got cycle=%0d q=%h r=%h dz=%b, expected cycle=%0d q=%h r=%h dz=%b",
                         a, b, sm, cyc, bus8.quotient, bus8.remainder, bus8.div_by_zero,
                         exp_cyc, eq[7:0], er[7:0], edz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
